fp_normalize: RTL and testbench

- Normalisation stage directly downstream of the floating-point mantissa adder.
- Input word format: {exponent[31:24], mantissa[23:0]}, unsigned, no sign bit. The adder also supplies its mantissa carry-out.
- Output is normalised so that mantissa bit 23 = 1, unless the result is zero or underflows.
- Iterative design: one left-shift per clock, with valid/ready handshakes on both sides.

---
 rtl/fp_normalize.sv | 161 ++++++++++++++++
 tb/tb_fp_normalize.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// Normalisation stage behind the mantissa adder. It takes a raw {exp, mant}
// sum plus the adder carry-out and produces a word with the mantissa MSB set.
// When the result is zero, or the exponent underflows first, it produces a
// flagged result instead. Left shifts are done one per clock.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// While out_valid is high, the result and its flags do not change until the
// edge that consumes them.
module fp_normalize #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_data,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_data,
    output logic                   out_zero,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic [CNT_W-1:0]       shift_count,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;

    logic [EXP_W-1:0] exp_in;
    logic [MAN_W-1:0] man_in;
    logic             exp_max;
    logic             direct_done;

    assign exp_in  = in_data[EXP_W+MAN_W-1:MAN_W];
    assign man_in  = in_data[MAN_W-1:0];
    assign exp_max = (exp_in == {EXP_W{1'b1}});

    // Carry, zero, already-normal and zero-exponent words all finish in one cycle.
    assign direct_done = in_carry || (man_in == '0) || man_in[MAN_W-1] || (exp_in == '0);

    assign out_data  = {e, m};
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = direct_done ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Stop when the shifted MSB becomes 1, or when the exponent reaches 0.
                // In SHIFT the exponent is always at least 1, so it never wraps.
                if (m[MAN_W-2] || (e == EXP_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture and classify on accept, shift in SHIFT, clear flags on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            e           <= '0;
            m           <= '0;
            shift_count <= '0;
            out_zero    <= 1'b0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_count <= '0;
                        out_zero    <= 1'b0;
                        out_ovf     <= 1'b0;
                        out_unf     <= 1'b0;
                        if (in_carry && !exp_max) begin
                            // The carry becomes the new MSB, and the LSB is truncated.
                            e <= exp_in + EXP_W'(1);
                            m <= {1'b1, man_in[MAN_W-1:1]};
                        end else if (in_carry) begin
                            // Exponent overflow: saturate the whole word.
                            e       <= '1;
                            m       <= '1;
                            out_ovf <= 1'b1;
                        end else if (man_in == '0) begin
                            // A zero mantissa drops the input exponent.
                            e        <= '0;
                            m        <= '0;
                            out_zero <= 1'b1;
                        end else begin
                            // Normal words and words needing shifts start from the raw value.
                            // With a zero exponent and MSB clear, no shift is possible.
                            e       <= exp_in;
                            m       <= man_in;
                            out_unf <= (exp_in == '0) && !man_in[MAN_W-1];
                        end
                    end
                end
                SHIFT: begin
                    e           <= e - EXP_W'(1);
                    m           <= {m[MAN_W-2:0], 1'b0};
                    shift_count <= shift_count + CNT_W'(1);
                    // Underflow only when the exponent runs out before the MSB is set.
                    out_unf     <= !m[MAN_W-2] && (e == EXP_W'(1));
                end
                DONE: begin
                    if (out_ready) begin
                        out_zero <= 1'b0;
                        out_ovf  <= 1'b0;
                        out_unf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed cases, backpressure, mid-shift reset, and
// a random stream checked against a behavioural model.
module tb_fp_normalize;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;
    logic [4:0]  shift_count;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected results: {data[31:0], zero, ovf, unf, count[4:0]}.
    logic [39:0] exp_q[$];

    fp_normalize dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .shift_count(shift_count),
        .state_dbg  (state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model computed from the normalisation rules.
    function automatic logic [39:0] ref_model(input logic [31:0] w, input logic c);
        int      e;
        longint  m;
        longint  t;
        int      pos;
        int      lz;
        int      n;
        logic    z;
        logic    o;
        logic    u;
        e   = int'(w[31:24]);
        m   = longint'(w[23:0]);
        z   = 1'b0;
        o   = 1'b0;
        u   = 1'b0;
        n   = 0;
        if (c && e < 255) begin
            m = (m + 64'd16777216) / 2;
            e = e + 1;
        end else if (c) begin
            e = 255;
            m = 64'hFFFFFF;
            o = 1'b1;
        end else if (m == 0) begin
            e = 0;
            z = 1'b1;
        end else begin
            t   = m;
            pos = 0;
            while (t > 1) begin
                t = t / 2;
                pos++;
            end
            lz = 23 - pos;
            n  = (lz < e) ? lz : e;
            m  = m * (64'd1 << n);
            e  = e - n;
            u  = (n < lz);
        end
        return {e[7:0], m[23:0], z, o, u, n[4:0]};
    endfunction

    // Drive one word with out_ready held high.
    // Then check the result, the flags, the shift count and the latency.
    task automatic run_one(input string tag, input logic [31:0] w, input logic c,
                           input logic [31:0] e_data, input logic [2:0] e_flags,
                           input int e_cnt, input int e_lat);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = w;
        in_carry  = c;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(e_lat));
        check_eq({tag, "_data"}, 64'(out_data), 64'(e_data));
        check_eq({tag, "_flags"}, 64'({out_zero, out_ovf, out_unf}), 64'(e_flags));
        check_eq({tag, "_count"}, 64'(shift_count), 64'(e_cnt));
        @(posedge clk);
    endtask

    initial begin
        logic [39:0] r;
        logic [39:0] exp_v;
        logic [31:0] w;
        logic        c;
        int          sent;
        int          got;
        int          cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_flags", 64'({out_zero, out_ovf, out_unf}), 64'd0);
        check_eq("rst_count", 64'(shift_count), 64'd0);
        reset = 1'b0;

        // Directed cases.
        run_one("shift23", 32'h20000001, 1'b0, 32'h09800000, 3'b000, 23, 24);
        run_one("carry",   32'h04C00000, 1'b1, 32'h05E00000, 3'b000, 0, 1);
        run_one("ovf",     32'hFF123456, 1'b1, 32'hFFFFFFFF, 3'b010, 0, 1);
        run_one("unf",     32'h05000001, 1'b0, 32'h00000020, 3'b001, 5, 6);
        run_one("zero",    32'h7A000000, 1'b0, 32'h00000000, 3'b100, 0, 1);
        run_one("exp0",    32'h00400000, 1'b0, 32'h00400000, 3'b001, 0, 1);
        run_one("normal",  32'h80ABCDEF, 1'b0, 32'h80ABCDEF, 3'b000, 0, 1);
        run_one("carry_fe", 32'hFEFFFFFF, 1'b1, 32'hFFFFFFFF, 3'b000, 0, 1);

        // Backpressure: the result is held and a waiting word is not taken.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h04C00000;
        in_carry  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data  = 32'h30800000;
        in_carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_data", 64'(out_data), 64'h05E00000);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check_eq("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_next_valid", 64'(out_valid), 64'd1);
        check_eq("bp_next_data", 64'(out_data), 64'h30800000);
        @(negedge clk);
        check_eq("bp_drained", 64'(in_ready), 64'd1);

        // Reset in the middle of a shift sequence.
        in_valid = 1'b1;
        in_data  = 32'h30000001;
        in_carry = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_in_shift", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_state", 64'(state_dbg), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_data", 64'(out_data), 64'd0);
        check_eq("mid_rst_flags", 64'({out_zero, out_ovf, out_unf}), 64'd0);
        check_eq("mid_rst_count", 64'(shift_count), 64'd0);
        run_one("post_rst", 32'h30800000, 1'b0, 32'h30800000, 3'b000, 0, 1);

        // Random stream with random backpressure, checked against the model.
        sent = 0;
        got  = 0;
        cyc  = 0;
        @(negedge clk);
        while (got < 20 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rnd_unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_eq("rnd_data", 64'(out_data), 64'(exp_v[39:8]));
                    check_eq("rnd_flags", 64'({out_zero, out_ovf, out_unf}), 64'(exp_v[7:5]));
                    check_eq("rnd_count", 64'(shift_count), 64'(exp_v[4:0]));
                end
                got++;
            end
            in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       w[31:24] = 8'($urandom_range(0, 12));
                1:       w[31:24] = 8'hFF;
                default: w[31:24] = 8'($urandom);
            endcase
            w[23:0]  = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom >> $urandom_range(0, 31));
            c        = ($urandom_range(0, 3) == 0);
            in_data  = w;
            in_carry = c;
            if (in_valid && in_ready) begin
                r = ref_model(w, c);
                exp_q.push_back(r);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("rnd_all_received", 64'(got), 64'd20);
        check_eq("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
